// File: rtl/sub_bytes_iter.sv
// Lane-shared AES SubBytes/InvSubBytes engine: LANES S-box pairs sweep the
// state buffer in BEATS steps, with valid/ready handshakes on both sides.

package sub_bytes_pkg;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
      else        r = r;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
  endfunction

endpackage

module sub_byte (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = sub_bytes_pkg::affine_fwd(sub_bytes_pkg::gf_inv(in_byte));
endmodule

module inv_sub_byte (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = sub_bytes_pkg::gf_inv(sub_bytes_pkg::affine_inv(in_byte));
endmodule

module sub_bytes_iter #(
  parameter int DATA_W = 128,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_mode,
  output logic              busy
);

  localparam int BEATS = DATA_W / (8 * LANES);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_buf;
  logic                r_mode;
  logic                w_in_ready;
  logic                w_accept;
  logic [DATA_W-1:0]   w_buf_sub;
  logic [7:0]          w_lane_in  [LANES];
  logic [7:0]          w_fwd      [LANES];
  logic [7:0]          w_inv      [LANES];
  logic [7:0]          w_lane_out [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sub_byte     u_fwd (.in_byte(w_lane_in[l]), .out_byte(w_fwd[l]));
    inv_sub_byte u_inv (.in_byte(w_lane_in[l]), .out_byte(w_inv[l]));
    assign w_lane_out[l] = r_mode ? w_inv[l] : w_fwd[l];
  end

  // Route the bytes of the current beat into the shared lanes.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_in[l] = 8'h00;
      for (int k = 0; k < BEATS; k++) begin
        w_lane_in[l] = w_lane_in[l] |
          ((r_cnt == CNT_W'(k)) ? r_buf[(k*LANES + l)*8 +: 8] : 8'h00);
      end
    end
  end

  // Write substituted lane bytes back to their original positions.
  always_comb begin
    w_buf_sub = r_buf;
    for (int k = 0; k < BEATS; k++) begin
      for (int l = 0; l < LANES; l++) begin
        w_buf_sub[(k*LANES + l)*8 +: 8] =
          (r_cnt == CNT_W'(k)) ? w_lane_out[l] : r_buf[(k*LANES + l)*8 +: 8];
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
        else          w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) w_state_nxt = S_DONE;
        else                   w_state_nxt = S_RUN;
      end
      S_DONE: begin
        // A new state only enters together with the result leaving.
        w_in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? S_RUN : S_IDLE;
        else           w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_accept = in_valid & w_in_ready & ~rst;

  // State register, beat counter and state buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_buf  <= in_data;
        r_mode <= in_mode;
        r_cnt  <= '0;
      end else if (r_state == S_RUN) begin
        r_buf <= w_buf_sub;
        if (r_cnt != LAST_CNT) r_cnt <= r_cnt + 1'b1;
        else                   r_cnt <= r_cnt;
      end else begin
        r_buf  <= r_buf;
        r_mode <= r_mode;
        r_cnt  <= r_cnt;
      end
    end
  end

  assign in_ready  = w_in_ready & ~rst;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_buf;
  assign out_mode  = r_mode;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Randomised and directed bench for sub_bytes_iter against a table-based
// S-box model built from GF(2^8) arithmetic by exhaustive search.

module tb_sub_bytes_iter;

  localparam int BEATS = 4;

  typedef struct packed {
    logic [127:0] data;
    logic         mode;
    logic [31:0]  acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_mode = 1'b0;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_mode;
  logic         busy;

  logic         sm_valid [2];
  logic         sm_iready[2];
  logic         sm_mode  [2];
  logic [127:0] sm_data  [2];
  logic         sm_ovalid[2];
  logic         sm_oready[2];
  logic [127:0] sm_odata [2];
  logic         sm_omode [2];
  logic         sm_busy  [2];

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   last_hs = -1;
  bit   started = 1'b0;
  exp_t q[$];
  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t[256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_iter #(.DATA_W(128), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode), .busy(busy)
  );

  sub_bytes_iter #(.DATA_W(128), .LANES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(sm_valid[0]), .in_ready(sm_iready[0]),
    .in_mode(sm_mode[0]), .in_data(sm_data[0]), .out_valid(sm_ovalid[0]),
    .out_ready(sm_oready[0]), .out_data(sm_odata[0]), .out_mode(sm_omode[0]),
    .busy(sm_busy[0])
  );

  sub_bytes_iter #(.DATA_W(128), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(sm_valid[1]), .in_ready(sm_iready[1]),
    .in_mode(sm_mode[1]), .in_data(sm_data[1]), .out_valid(sm_ovalid[1]),
    .out_ready(sm_oready[1]), .out_data(sm_odata[1]), .out_mode(sm_omode[1]),
    .busy(sm_busy[1])
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Polynomial product followed by long-division reduction mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_sub(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int b = 0; b < 16; b++)
      r[b*8 +: 8] = m ? isbox_t[d[b*8 +: 8]] : sbox_t[d[b*8 +: 8]];
    return r;
  endfunction

  // Per-cycle comparison of the main instance against the transaction model.
  always @(negedge clk) begin
    bit done_m;
    if (rst) begin
      chk("in_ready_in_reset", {127'd0, in_ready}, 128'd0);
    end else if (started) begin
      done_m = (q.size() > 0) && ((cyc - int'(q[0].acc)) >= BEATS);
      chk("out_valid", {127'd0, out_valid}, {127'd0, done_m});
      chk("busy", {127'd0, busy}, {127'd0, (q.size() > 0)});
      chk("in_ready", {127'd0, in_ready},
          {127'd0, (q.size() == 0) || (done_m && out_ready)});
      if (done_m) begin
        chk("out_data", out_data, q[0].data);
        chk("out_mode", {127'd0, out_mode}, {127'd0, q[0].mode});
        if (out_ready) begin
          last_hs = cyc + 1;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic m, output int acc);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout actual=no_accept expected=accept");
      in_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      q.push_back({model_sub(d, m), m, 32'(acc)});
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_mode  = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 60 && q.size() > 0; n++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout actual=%0d expected=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_small(input int s, input int exp_lat);
    int  acc;
    bit  ok;
    logic [127:0] d;
    d = {16{8'h63}};
    sm_valid[s]  = 1'b1;
    sm_data[s]   = d;
    sm_mode[s]   = 1'b1;
    sm_oready[s] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (sm_iready[s]) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    sm_valid[s] = 1'b0;
    sm_data[s]  = {$urandom, $urandom, $urandom, $urandom};
    sm_mode[s]  = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (sm_ovalid[s]) ok = 1'b1;
    end
    chk($sformatf("small%0d_latency", s), 128'(cyc - acc), 128'(exp_lat));
    chk($sformatf("small%0d_data", s), sm_odata[s], model_sub(d, 1'b1));
    chk($sformatf("small%0d_data_lit", s), sm_odata[s], 128'd0);
    chk($sformatf("small%0d_mode", s), {127'd0, sm_omode[s]}, 128'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a;
    int a2;
    int prev;
    logic [127:0] d;
    logic         m;
    for (int s = 0; s < 2; s++) begin
      sm_valid[s] = 1'b0; sm_mode[s] = 1'b0; sm_data[s] = '0; sm_oready[s] = 1'b0;
    end
    build_tables();
    chk("model_sbox_00", 128'(sbox_t[0]), 128'h63);
    chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    chk("model_isbox_63", 128'(isbox_t[8'h63]), 128'h00);
    chk("model_fwd_vec", model_sub(128'h00112233445566778899aabbccddeeff, 1'b0),
        128'h638293c31bfc33f5c4eeacea4bc12816);
    chk("model_inv_vec", model_sub(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1),
        128'h00112233445566778899aabbccddeeff);
    chk("model_53_vec", model_sub({16{8'h53}}, 1'b0), {16{8'hed}});

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset_out_data", out_data, 128'd0);
    chk("reset_out_mode", {127'd0, out_mode}, 128'd0);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;

    // Reset while the state is being processed.
    send(128'd0, 1'b0, a);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midreset_busy", {127'd0, busy}, 128'd0);
    chk("midreset_in_ready", {127'd0, in_ready}, 128'd1);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;

    send(128'h00112233445566778899aabbccddeeff, 1'b0, a);
    wait_idle();
    send(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, a);
    wait_idle();

    // Backpressure, then simultaneous output and input handshakes.
    out_ready = 1'b0;
    send(128'd0, 1'b0, a);
    repeat (BEATS + 10) @(negedge clk);
    chk("bp_held_data", out_data, {16{8'h63}});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send({16{8'h53}}, 1'b0, a2);
    chk("bp_same_cycle_hs", 128'(a2), 128'(last_hs));
    wait_idle();

    // Streaming with continuous ready.
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom);
      send(d, m, a);
      if (i > 0) chk("stream_interval", 128'(a - prev), 128'(BEATS + 1));
      prev = a;
    end
    wait_idle();

    run_small(0, 1);
    run_small(1, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
